mc_sequencer: RTL and testbench
===============================

# mc_sequencer

- Multicycle main controller for the 5-bit-address, word-addressed MIPS datapath.
- Decodes the latched instruction's `op`/`funct` and steps a Moore state machine.
- Drives every datapath select and write strobe: PC, IR, register file, memory, ALU.
- Also provides a run/hold gate, a sticky illegal-instruction flag and a retired-instruction counter for bring-up and debug.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  1 = permit fetch of the next instruction; sampled only in FETCH
- op  in  6  instr[31:26] from datapath IR
- funct  in  6  instr[5:0] from datapath IR
- pcwrite, irwrite, regwrite, memwrite, branch  out  1 each  write strobes
- IorD, alusrcA, regdst, mem2reg, pcsrc  out  1 each  mux selects (datapath meaning: IorD 1 = aluout address; alusrcA 1 = rd1; regdst 1 = instr[15:11]; mem2reg 1 = memory data; pcsrc 1 = aluout)
- alusrcB  out  2  00 = const 1, 01 = rd2, 1x = zero-extended imm
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state encoding
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  sticky; set on unsupported op/funct
- retired  out  CNT_W  count of instr_done pulses

## Operation
Signal defaults:
- Outputs are decoded from `state`.
- Unless listed: strobes 0, selects 0, alusrcB 00, alucontrol 010.

States (encoding in brackets) and transitions:
- FETCH [0]:
  - If run=1: IorD=0, irwrite=1, alusrcA=0, alusrcB=00, add, pcsrc=0, pcwrite=1; go to DECODE.
  - If run=0: all strobes 0; stay in FETCH.
- DECODE [1]: alusrcA=0, alusrcB=10, add (branch target into aluout). Next state by `op`:
  - 100011 or 101011 -> MEMADR
  - 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - anything else -> FETCH, with illegal set and instr_done pulsed.
- MEMADR [2]: alusrcA=1, alusrcB=10, add; go to MEMRD if op=100011, else MEMWR.
- MEMRD [3]: IorD=1; go to MEMWB.
- MEMWB [4]: regdst=0, mem2reg=1, regwrite=1, instr_done; go to FETCH.
- MEMWR [5]: IorD=1, memwrite=1, instr_done; go to FETCH.
- EXECUTE [6]: alusrcA=1, alusrcB=01; alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); go to ALUWB.
- ALUWB [7]: regdst=1, mem2reg=0, regwrite=1, instr_done; go to FETCH.
- BRANCH [8]: alusrcA=1, alusrcB=01, sub, branch=1, pcsrc=1, instr_done; go to FETCH. The datapath forms pcen = branch&zero.
- ADDIEX [9]: alusrcA=1, alusrcB=10, add; go to ADDIWB.
- ADDIWB [10]: regdst=0, mem2reg=0, regwrite=1, instr_done; go to FETCH.
- Encodings 11-15: go to FETCH next cycle; all strobes 0; illegal set.

Counter and illegal flag:
- `retired` increments by 1 on every instr_done and wraps from 2^CNT_W-1 to 0.
- `illegal` clears only on reset.

## Timing
Reset:
- Async assert: state=FETCH, illegal=0, retired=0.
- While reset=0, pcwrite/irwrite/regwrite/memwrite/branch are forced 0 combinationally.
- Deassertion takes effect at the next rising clk.
- Reset mid-instruction aborts the instruction: no further strobes, and no instr_done for it.

Latency, counted from a FETCH cycle with run=1 to the final cycle inclusive:
- lw 5
- sw 4
- R-type 4
- addi 4
- beq 3
- illegal 2

Sequencing rules:
- `op`/`funct` are used only from DECODE onward, after the IR loads on the FETCH edge.
- The datapath's aluout register captures the ALU every cycle; each writeback/branch state consumes the value produced in the preceding state.
- `run` is ignored outside FETCH, so an instruction in flight always completes.
- instr_done and the counter increment occur on the same clock edge that leaves the final state.

## Configuration
- MC_SEQUENCER_ADDI_EN:
  - Defined: ADDIEX/ADDIWB exist and op 001000 executes as above.
  - Undefined: those states are not built; op 001000 decodes as illegal (DECODE -> FETCH, illegal set); encodings 9-10 behave as unused encodings.

## Test plan
- Hold reset=0 with run=1 for 3 clocks -> state=0, all strobes 0, illegal=0, retired=0; release -> first FETCH shows pcwrite=irwrite=1 and alusrcB=00.
- lw (op 100011) with run=1 -> states 0,1,2,3,4; regwrite=1 and mem2reg=1 only in state 4; retired 0->1.
- R-type sub (op 000000, funct 100010) -> EXECUTE alucontrol=110, alusrcB=01; ALUWB regdst=1 and regwrite=1; 4 cycles total.
- beq (op 000100) -> states 0,1,8; branch=1, pcsrc=1, alucontrol=110 in state 8; back to FETCH on the next edge.
- Illegal op 111111 -> DECODE -> FETCH, illegal=1 persists through 3 further valid instructions, retired +1.
- run=0 in FETCH for 4 cycles -> no strobes, state stays 0; assert reset=0 mid-lw (state 3) -> immediate state=0, no regwrite, retired unchanged.

Source files
------------

// File: rtl/mc_sequencer_if.sv
// Control bus between the multicycle sequencer (master) and the MIPS datapath (slave).
// Carries the IR fields in, and every select, strobe and debug status out.
interface mc_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             pcwrite, irwrite, regwrite, memwrite, branch;
   logic             IorD, alusrcA, regdst, mem2reg, pcsrc;
   logic [1:0]       alusrcB;
   logic [2:0]       alucontrol;
   logic [3:0]       state;
   logic             instr_done;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  run, op, funct,
      output pcwrite, irwrite, regwrite, memwrite, branch,
      output IorD, alusrcA, regdst, mem2reg, pcsrc,
      output alusrcB, alucontrol, state, instr_done, illegal, retired
   );

   modport slave (
      output run, op, funct,
      input  pcwrite, irwrite, regwrite, memwrite, branch,
      input  IorD, alusrcA, regdst, mem2reg, pcsrc,
      input  alusrcB, alucontrol, state, instr_done, illegal, retired
   );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle MIPS main controller: Moore FSM plus run gate, sticky illegal flag, retire counter.
// Define MC_SEQUENCER_ADDI_EN to build the ADDIEX/ADDIWB states for addi.
module mc_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   mc_sequencer_if.master bus
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_SEQUENCER_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8
`ifdef MC_SEQUENCER_ADDI_EN
      , ADDIEX = 4'd9,
      ADDIWB  = 4'd10
`endif
   } state_t;

   state_t           state;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   logic is_mem, is_rtype, is_beq, is_addi, legal;
   logic pcwrite, irwrite, regwrite, memwrite, branch, done;
   logic [2:0] funct_alu;

   assign is_mem   = (bus.op == OP_LW) || (bus.op == OP_SW);
   assign is_beq   = (bus.op == OP_BEQ);
   assign is_rtype = (bus.op == OP_RTYPE) &&
                     (bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
`ifdef MC_SEQUENCER_ADDI_EN
   assign is_addi  = (bus.op == OP_ADDI);
`else
   assign is_addi  = 1'b0;
`endif
   assign legal    = is_mem || is_rtype || is_beq || is_addi;

   always_comb begin
      funct_alu = 3'b010;
      case (bus.funct)
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_alu = 3'b010;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= FETCH;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         if (done) retired <= retired + 1'b1;
         case (state)
            FETCH:   if (bus.run) state <= DECODE;
            DECODE: begin
               if (is_mem)        state <= MEMADR;
               else if (is_rtype) state <= EXECUTE;
               else if (is_beq)   state <= BRANCH;
`ifdef MC_SEQUENCER_ADDI_EN
               else if (is_addi)  state <= ADDIEX;
`endif
               else begin
                  state   <= FETCH;
                  illegal <= 1'b1;
               end
            end
            MEMADR:  state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state <= MEMWB;
            EXECUTE: state <= ALUWB;
`ifdef MC_SEQUENCER_ADDI_EN
            ADDIEX:  state <= ADDIWB;
            ADDIWB:  state <= FETCH;
`endif
            MEMWB, MEMWR, ALUWB, BRANCH: state <= FETCH;
            default: begin
               state   <= FETCH;
               illegal <= 1'b1;
            end
         endcase
      end
   end

   // Outputs follow state; only FETCH looks at run and only DECODE looks at the opcode.
   always_comb begin
      pcwrite        = 1'b0;
      irwrite        = 1'b0;
      regwrite       = 1'b0;
      memwrite       = 1'b0;
      branch         = 1'b0;
      done           = 1'b0;
      bus.IorD       = 1'b0;
      bus.alusrcA    = 1'b0;
      bus.regdst     = 1'b0;
      bus.mem2reg    = 1'b0;
      bus.pcsrc      = 1'b0;
      bus.alusrcB    = 2'b00;
      bus.alucontrol = 3'b010;
      case (state)
         FETCH: if (bus.run) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
         end
         DECODE: begin
            bus.alusrcB = 2'b10;
            done        = !legal;
         end
         MEMADR: begin
            bus.alusrcA = 1'b1;
            bus.alusrcB = 2'b10;
         end
         MEMRD: bus.IorD = 1'b1;
         MEMWB: begin
            bus.mem2reg = 1'b1;
            regwrite    = 1'b1;
            done        = 1'b1;
         end
         MEMWR: begin
            bus.IorD = 1'b1;
            memwrite = 1'b1;
            done     = 1'b1;
         end
         EXECUTE: begin
            bus.alusrcA    = 1'b1;
            bus.alusrcB    = 2'b01;
            bus.alucontrol = funct_alu;
         end
         ALUWB: begin
            bus.regdst = 1'b1;
            regwrite   = 1'b1;
            done       = 1'b1;
         end
         BRANCH: begin
            bus.alusrcA    = 1'b1;
            bus.alusrcB    = 2'b01;
            bus.alucontrol = 3'b110;
            bus.pcsrc      = 1'b1;
            branch         = 1'b1;
            done           = 1'b1;
         end
`ifdef MC_SEQUENCER_ADDI_EN
         ADDIEX: begin
            bus.alusrcA = 1'b1;
            bus.alusrcB = 2'b10;
         end
         ADDIWB: begin
            regwrite = 1'b1;
            done     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Strobes are gated by reset so a held reset can never write architectural state.
   assign bus.pcwrite    = pcwrite  & reset;
   assign bus.irwrite    = irwrite  & reset;
   assign bus.regwrite   = regwrite & reset;
   assign bus.memwrite   = memwrite & reset;
   assign bus.branch     = branch   & reset;
   assign bus.instr_done = done;
   assign bus.state      = state;
   assign bus.illegal    = illegal;
   assign bus.retired    = retired;
endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle state/control vectors checked against hand values.
module tb_mc_sequencer;
   localparam int CNT_W = 4;

   // {pcwrite,irwrite,regwrite,memwrite,branch, IorD,alusrcA,regdst,mem2reg,pcsrc, alusrcB, alucontrol, instr_done}
   localparam logic [15:0] C_IDLE    = 16'b00000_00000_00_010_0;
   localparam logic [15:0] C_FETCH   = 16'b11000_00000_00_010_0;
   localparam logic [15:0] C_DEC     = 16'b00000_00000_10_010_0;
   localparam logic [15:0] C_DEC_ILL = 16'b00000_00000_10_010_1;
   localparam logic [15:0] C_MEMADR  = 16'b00000_01000_10_010_0;
   localparam logic [15:0] C_MEMRD   = 16'b00000_10000_00_010_0;
   localparam logic [15:0] C_MEMWB   = 16'b00100_00010_00_010_1;
   localparam logic [15:0] C_MEMWR   = 16'b00010_10000_00_010_1;
   localparam logic [15:0] C_ALUWB   = 16'b00100_00100_00_010_1;
   localparam logic [15:0] C_BRANCH  = 16'b00001_01001_01_110_1;
`ifdef MC_SEQUENCER_ADDI_EN
   localparam logic [15:0] C_ADDIEX  = 16'b00000_01000_10_010_0;
   localparam logic [15:0] C_ADDIWB  = 16'b00100_00000_00_010_1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [CNT_W-1:0] exp_ret = '0;
   logic [15:0] ctl;

   mc_sequencer_if #(.CNT_W(CNT_W)) b();
   mc_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(b.master));

   always #5 clk = ~clk;

   assign ctl = {b.pcwrite, b.irwrite, b.regwrite, b.memwrite, b.branch,
                 b.IorD, b.alusrcA, b.regdst, b.mem2reg, b.pcsrc,
                 b.alusrcB, b.alucontrol, b.instr_done};

   // Advance one clock, then drop run so FETCH parks after the instruction.
   task automatic tick();
      @(posedge clk); #1;
      b.run = 1'b0;
      #1;
   endtask

   task automatic start(input logic [5:0] op, input logic [5:0] funct);
      b.op = op; b.funct = funct; b.run = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; b.run = 1'b1; b.op = 6'b100011; b.funct = 6'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (b.state !== 4'd0 || ctl !== C_IDLE || b.illegal !== 1'b0 || b.retired !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold: state=%0d ctl=%h ill=%b ret=%0d, expected 0 %h 0 0", b.state, ctl, b.illegal, b.retired, C_IDLE);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (b.state !== 4'd0 || ctl !== C_FETCH) begin
         errors++;
         $display("FAIL reset_release_fetch: state=%0d ctl=%h, expected 0 %h", b.state, ctl, C_FETCH);
      end
      b.run = 1'b0;
      #1;
   endtask

   task automatic test_lw();
      logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      logic [15:0] cv [5] = '{C_FETCH, C_DEC, C_MEMADR, C_MEMRD, C_MEMWB};
      start(6'b100011, 6'b000000);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (b.state !== st[i] || ctl !== cv[i] || b.retired !== exp_ret) begin
            errors++;
            $display("FAIL lw cyc%0d: state=%0d ctl=%h ret=%0d, expected %0d %h %0d", i, b.state, ctl, b.retired, st[i], cv[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL lw_retire: state=%0d ret=%0d, expected 0 %0d", b.state, b.retired, exp_ret);
      end
   endtask

   task automatic test_sw();
      logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      logic [15:0] cv [4] = '{C_FETCH, C_DEC, C_MEMADR, C_MEMWR};
      start(6'b101011, 6'b000000);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b.state !== st[i] || ctl !== cv[i] || b.retired !== exp_ret) begin
            errors++;
            $display("FAIL sw cyc%0d: state=%0d ctl=%h ret=%0d, expected %0d %h %0d", i, b.state, ctl, b.retired, st[i], cv[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL sw_retire: state=%0d ret=%0d, expected 0 %0d", b.state, b.retired, exp_ret);
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn  [5] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
      logic [2:0] alu [5] = '{3'b110, 3'b010, 3'b000, 3'b001, 3'b111};
      logic [3:0] st  [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
      logic [15:0] cv [4];
      for (int k = 0; k < 5; k++) begin
         cv = '{C_FETCH, C_DEC, {12'b00000_01000_01, alu[k], 1'b0}, C_ALUWB};
         start(6'b000000, fn[k]);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (b.state !== st[i] || ctl !== cv[i] || b.retired !== exp_ret) begin
               errors++;
               $display("FAIL rtype f%b cyc%0d: state=%0d ctl=%h ret=%0d, expected %0d %h %0d", fn[k], i, b.state, ctl, b.retired, st[i], cv[i], exp_ret);
            end
            tick();
         end
         exp_ret++;
         checks++;
         if (b.state !== 4'd0 || b.retired !== exp_ret) begin
            errors++;
            $display("FAIL rtype_retire f%b: state=%0d ret=%0d, expected 0 %0d", fn[k], b.state, b.retired, exp_ret);
         end
      end
   endtask

   task automatic test_beq();
      logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd8};
      logic [15:0] cv [3] = '{C_FETCH, C_DEC, C_BRANCH};
      start(6'b000100, 6'b000000);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (b.state !== st[i] || ctl !== cv[i] || b.retired !== exp_ret) begin
            errors++;
            $display("FAIL beq cyc%0d: state=%0d ctl=%h ret=%0d, expected %0d %h %0d", i, b.state, ctl, b.retired, st[i], cv[i], exp_ret);
         end
         tick();
      end
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL beq_retire: state=%0d ret=%0d, expected 0 %0d", b.state, b.retired, exp_ret);
      end
   endtask

   task automatic test_run_hold();
      b.op = 6'b100011; b.run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b.state !== 4'd0 || ctl !== C_IDLE) begin
            errors++;
            $display("FAIL run_hold cyc%0d: state=%0d ctl=%h, expected 0 %h", i, b.state, ctl, C_IDLE);
         end
         @(posedge clk); #2;
      end
   endtask

   task automatic test_illegal();
      checks++;
      if (b.illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pre: illegal=%b, expected 0", b.illegal);
      end
      start(6'b111111, 6'b000000);
      checks++;
      if (b.state !== 4'd0 || ctl !== C_FETCH) begin
         errors++;
         $display("FAIL illegal_fetch: state=%0d ctl=%h, expected 0 %h", b.state, ctl, C_FETCH);
      end
      tick();
      checks++;
      if (b.state !== 4'd1 || ctl !== C_DEC_ILL || b.illegal !== 1'b0) begin
         errors++;
         $display("FAIL illegal_decode: state=%0d ctl=%h ill=%b, expected 1 %h 0", b.state, ctl, b.illegal, C_DEC_ILL);
      end
      tick();
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.illegal !== 1'b1 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL illegal_after: state=%0d ill=%b ret=%0d, expected 0 1 %0d", b.state, b.illegal, b.retired, exp_ret);
      end
      for (int k = 0; k < 3; k++) begin
         start(6'b000100, 6'b000000);
         repeat (3) tick();
         exp_ret++;
         checks++;
         if (b.state !== 4'd0 || b.illegal !== 1'b1 || b.retired !== exp_ret) begin
            errors++;
            $display("FAIL illegal_sticky%0d: state=%0d ill=%b ret=%0d, expected 0 1 %0d", k, b.state, b.illegal, b.retired, exp_ret);
         end
      end
      // R-type opcode with an unsupported funct decodes as illegal too
      start(6'b000000, 6'b000000);
      tick();
      checks++;
      if (b.state !== 4'd1 || ctl !== C_DEC_ILL) begin
         errors++;
         $display("FAIL bad_funct_decode: state=%0d ctl=%h, expected 1 %h", b.state, ctl, C_DEC_ILL);
      end
      tick();
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL bad_funct_after: state=%0d ret=%0d, expected 0 %0d", b.state, b.retired, exp_ret);
      end
   endtask

   task automatic test_addi();
`ifdef MC_SEQUENCER_ADDI_EN
      logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd9, 4'd10};
      logic [15:0] cv [4] = '{C_FETCH, C_DEC, C_ADDIEX, C_ADDIWB};
      localparam int N = 4;
`else
      logic [3:0]  st [2] = '{4'd0, 4'd1};
      logic [15:0] cv [2] = '{C_FETCH, C_DEC_ILL};
      localparam int N = 2;
`endif
      start(6'b001000, 6'b000000);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (b.state !== st[i] || ctl !== cv[i]) begin
            errors++;
            $display("FAIL addi cyc%0d: state=%0d ctl=%h, expected %0d %h", i, b.state, ctl, st[i], cv[i]);
         end
         tick();
      end
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL addi_retire: state=%0d ret=%0d, expected 0 %0d", b.state, b.retired, exp_ret);
      end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 18; k++) begin
         start(6'b000100, 6'b000000);
         repeat (3) tick();
         exp_ret++;
         checks++;
         if (b.retired !== exp_ret) begin
            errors++;
            $display("FAIL wrap%0d: ret=%0d, expected %0d", k, b.retired, exp_ret);
         end
      end
   endtask

   task automatic test_reset_mid();
      start(6'b100011, 6'b000000);
      repeat (3) tick();
      checks++;
      if (b.state !== 4'd3) begin
         errors++;
         $display("FAIL mid_reach_memrd: state=%0d, expected 3", b.state);
      end
      reset = 1'b0;
      #1;
      exp_ret = '0;
      checks++;
      if (b.state !== 4'd0 || ctl !== C_IDLE || b.illegal !== 1'b0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL mid_reset_async: state=%0d ctl=%h ill=%b ret=%0d, expected 0 %h 0 0", b.state, ctl, b.illegal, b.retired, C_IDLE);
      end
      b.run = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (b.state !== 4'd0 || b.regwrite !== 1'b0 || ctl !== C_IDLE || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL mid_reset_held: state=%0d ctl=%h ret=%0d, expected 0 %h 0", b.state, ctl, b.retired, C_IDLE);
      end
      b.run = 1'b0;
      reset = 1'b1;
      #1;
      start(6'b000100, 6'b000000);
      repeat (3) tick();
      exp_ret++;
      checks++;
      if (b.state !== 4'd0 || b.retired !== exp_ret) begin
         errors++;
         $display("FAIL mid_reset_recover: state=%0d ret=%0d, expected 0 %0d", b.state, b.retired, exp_ret);
      end
   endtask

   initial begin
      b.run = 1'b0; b.op = 6'b0; b.funct = 6'b0;
      test_reset();
      test_lw();
      test_sw();
      test_rtype();
      test_beq();
      test_run_hold();
      test_illegal();
      test_addi();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
